// File: rtl/dm_pkg.sv
// Shared types and constants for the sized data memory.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_e;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dm_if.sv
// Request/acknowledge bus between the datapath and the data memory.
interface dm_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  ready_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output ready_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/dm_byte_lane.sv
// Little-endian lane steering: store byte enables / replicated data, load extract and extend.
module dm_byte_lane
    import dm_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Store data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        unique case (size)
            SZ_B: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        byte_v = rword[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rword[31:16] : rword[15:0];
        rdata  = '0;
        unique case (size)
            SZ_B:    rdata = unsigned_ld ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    rdata = unsigned_ld ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            SZ_W:    rdata = rword;
            default: rdata = '0;
        endcase
    end
endmodule

// File: rtl/dm_sized.sv
// Parametrised byte/half/word data memory with a wait-state handshake and access error reporting.
module dm_sized
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic clk,
    input logic rst_n,
    dm_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [CNT_W-1:0] WAIT_LD = HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, uns_q;
    size_e            size_q;
    logic [31:0]      addr_q, wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        ready, accept, do_access;
    logic        acc_we, acc_uns, acc_err;
    size_e       acc_size;
    logic [31:0] acc_addr, acc_wdata;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wword, rword, ld_val;

    assign ready  = (state_q != ST_WAIT);
    assign accept = bus.req_i && ready;

    // With no wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state_q == ST_WAIT) begin
            acc_we    = we_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end else begin
            acc_we    = bus.we_i;
            acc_size  = size_e'(bus.size_i);
            acc_uns   = bus.unsigned_i;
            acc_addr  = bus.addr_i;
            acc_wdata = bus.wdata_i;
        end
    end

    assign do_access = ((state_q == ST_WAIT) && (cnt_q == '0)) || (accept && !HAS_WAIT);
    assign idx       = acc_addr[AW+1:2];
    assign rword     = mem[idx];

    assign acc_err = (acc_size == SZ_RSV)
                  || ((acc_size == SZ_H) && acc_addr[0])
                  || ((acc_size == SZ_W) && (acc_addr[1:0] != 2'b00))
                  || ((acc_addr >> (AW + 2)) != 32'd0);

    dm_byte_lane u_lane (
        .size        (acc_size),
        .addr_lo     (acc_addr[1:0]),
        .unsigned_ld (acc_uns),
        .wdata       (acc_wdata),
        .rword       (rword),
        .be          (be),
        .wword       (wword),
        .rdata       (ld_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_ACK: begin
                if (accept) begin
                    state_d = HAS_WAIT ? ST_WAIT : ST_ACK;
                    cnt_d   = WAIT_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.we_i;
                size_q  <= size_e'(bus.size_i);
                uns_q   <= bus.unsigned_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wdata_i;
            end
            if (do_access) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? 32'd0 : ld_val;
            end
        end
    end

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem[idx][8*l +: 8] <= wword[8*l +: 8];
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.ack_o   = (state_q == ST_ACK);
    assign bus.rdata_o = rdata_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_dm_sized.sv
// Directed bench for dm_sized: three instances with 0, 2 and 3 wait states.
module tb_dm_sized;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_if b0 ();
    dm_if b2 ();
    dm_if b3 ();

    dm_sized #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    dm_sized #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    dm_sized #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    int n_vec = 0;
    int n_bad = 0;

    task automatic drive(input int which, input logic req, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        case (which)
            0: begin
                b0.req_i = req; b0.we_i = we; b0.size_i = size;
                b0.unsigned_i = uns; b0.addr_i = addr; b0.wdata_i = wdata;
            end
            2: begin
                b2.req_i = req; b2.we_i = we; b2.size_i = size;
                b2.unsigned_i = uns; b2.addr_i = addr; b2.wdata_i = wdata;
            end
            default: begin
                b3.req_i = req; b3.we_i = we; b3.size_i = size;
                b3.unsigned_i = uns; b3.addr_i = addr; b3.wdata_i = wdata;
            end
        endcase
    endtask

    task automatic sample(input int which, output logic rdy, output logic ack,
                          output logic [31:0] rd, output logic er);
        case (which)
            0:       begin rdy = b0.ready_o; ack = b0.ack_o; rd = b0.rdata_o; er = b0.err_o; end
            2:       begin rdy = b2.ready_o; ack = b2.ack_o; rd = b2.rdata_o; er = b2.err_o; end
            default: begin rdy = b3.ready_o; ack = b3.ack_o; rd = b3.rdata_o; er = b3.err_o; end
        endcase
    endtask

    // One request from idle; lat = cycles from accept edge to ack, -1 on timeout.
    task automatic access(input int which, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output int lat);
        logic rdy, ack;
        @(negedge clk);
        drive(which, 1'b1, we, size, uns, addr, wdata);
        @(posedge clk);
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) drive(which, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
            sample(which, rdy, ack, rd, er);
            if (ack) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic rdy, ack, er;
        logic [31:0] rd;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive(2, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive(3, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sample(0, rdy, ack, rd, er);
        n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", rdy); end
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
        n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", er); end
        n_vec++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rd); end
        sample(3, rdy, ack, rd, er);
        n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_ready_w3 got %b want 1", rdy); end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic er;
        int lat;
        access(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h8000_00FF, rd, er, lat);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL sw_latency got %0d want 1", lat); end
        n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL sw_err got %b want 0", er); end
        access(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'd0, rd, er, lat);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL lw_latency got %0d want 1", lat); end
        n_vec++; if (rd !== 32'h8000_00FF) begin n_bad++; $display("FAIL lw_rdata got %h want 800000ff", rd); end
        n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL lw_err got %b want 0", er); end
    endtask

    task automatic test_merge();
        logic [31:0] rd;
        logic er;
        int lat;
        access(0, 1'b1, SZ_W, 1'b0, 32'h20, 32'h1122_3344, rd, er, lat);
        access(0, 1'b1, SZ_B, 1'b0, 32'h21, 32'h0000_00AB, rd, er, lat);
        access(0, 1'b1, SZ_H, 1'b0, 32'h22, 32'h0000_BEEF, rd, er, lat);
        access(0, 1'b0, SZ_W, 1'b0, 32'h20, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'hBEEF_AB44) begin n_bad++; $display("FAIL merge_lw got %h want beefab44", rd); end
        access(0, 1'b0, SZ_B, 1'b0, 32'h21, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'hFFFF_FFAB) begin n_bad++; $display("FAIL lb got %h want ffffffab", rd); end
        access(0, 1'b0, SZ_B, 1'b1, 32'h21, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'h0000_00AB) begin n_bad++; $display("FAIL lbu got %h want 000000ab", rd); end
        access(0, 1'b0, SZ_H, 1'b0, 32'h22, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'hFFFF_BEEF) begin n_bad++; $display("FAIL lh got %h want ffffbeef", rd); end
        access(0, 1'b0, SZ_H, 1'b1, 32'h20, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'h0000_AB44) begin n_bad++; $display("FAIL lhu got %h want 0000ab44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat;
        access(0, 1'b1, SZ_W, 1'b0, 32'h24, 32'h0102_0304, rd, er, lat);
        access(0, 1'b0, SZ_H, 1'b0, 32'h23, 32'd0, rd, er, lat);
        n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL lh_misalign_err got %b want 1", er); end
        n_vec++; if (rd !== 32'd0) begin n_bad++; $display("FAIL lh_misalign_rdata got %h want 0", rd); end
        access(0, 1'b1, SZ_W, 1'b0, 32'h26, 32'hFFFF_FFFF, rd, er, lat);
        n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL sw_misalign_err got %b want 1", er); end
        access(0, 1'b0, SZ_W, 1'b0, 32'h24, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'h0102_0304) begin n_bad++; $display("FAIL sw_misalign_nowrite got %h want 01020304", rd); end
        n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL aligned_err got %b want 0", er); end
        access(0, 1'b0, SZ_RSV, 1'b0, 32'h24, 32'd0, rd, er, lat);
        n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL rsv_err got %b want 1", er); end
        n_vec++; if (rd !== 32'd0) begin n_bad++; $display("FAIL rsv_rdata got %h want 0", rd); end
        access(0, 1'b1, SZ_W, 1'b0, 32'h0, 32'hCAFE_F00D, rd, er, lat);
        access(0, 1'b1, SZ_W, 1'b0, 32'h400, 32'hDEAD_BEEF, rd, er, lat);
        n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL range_err got %b want 1", er); end
        access(0, 1'b0, SZ_W, 1'b0, 32'h0, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL range_nowrite got %h want cafef00d", rd); end
    endtask

    task automatic test_wait();
        logic rdy, ack, er, exp_ack;
        logic [31:0] rd;
        @(negedge clk);
        drive(3, 1'b1, 1'b1, SZ_W, 1'b0, 32'h30, 32'h1234_5678);
        @(posedge clk);
        // Cycle 0 accepted the store; a load is then held through the wait states.
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) drive(3, 1'b1, 1'b0, SZ_W, 1'b0, 32'h30, 32'd0);
            if (c == 8) drive(3, 1'b0, 1'b0, SZ_W, 1'b0, 32'h30, 32'd0);
            sample(3, rdy, ack, rd, er);
            exp_ack = (c == 4) || (c == 8);
            n_vec++;
            if (ack !== exp_ack) begin
                n_bad++; $display("FAIL wait_ack cycle %0d got %b want %b", c, ack, exp_ack);
            end
            n_vec++;
            if (rdy !== exp_ack) begin
                n_bad++; $display("FAIL wait_ready cycle %0d got %b want %b", c, rdy, exp_ack);
            end
            if (c == 8) begin
                n_vec++;
                if (rd !== 32'h1234_5678) begin
                    n_bad++; $display("FAIL wait_rdata got %h want 12345678", rd);
                end
            end
        end
        @(negedge clk);
        sample(3, rdy, ack, rd, er);
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wait_ack_pulse got %b want 0", ack); end
    endtask

    task automatic test_reset_mid();
        logic rdy, ack, er, seen;
        logic [31:0] rd;
        int lat;
        access(2, 1'b1, SZ_W, 1'b0, 32'h8, 32'h0000_00AA, rd, er, lat);
        n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL w2_latency got %0d want 3", lat); end
        @(negedge clk);
        drive(2, 1'b1, 1'b1, SZ_W, 1'b0, 32'h8, 32'h0000_0005);
        @(posedge clk);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        sample(2, rdy, ack, rd, er);
        n_vec++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL mid_in_wait got %b want 0", rdy); end
        rst_n = 1'b0;
        #1;
        sample(2, rdy, ack, rd, er);
        n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL mid_async_idle got %b want 1", rdy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            sample(2, rdy, ack, rd, er);
            if (ack) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_ack got %b want 0", seen); end
        access(2, 1'b0, SZ_W, 1'b0, 32'h8, 32'd0, rd, er, lat);
        n_vec++; if (rd !== 32'h0000_00AA) begin n_bad++; $display("FAIL mid_dropped got %h want 000000aa", rd); end
    endtask

    task automatic test_back_to_back();
        logic rdy, ack, er;
        logic [31:0] rd;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, SZ_W, 1'b0, 32'h40, 32'hA5A5_0F0F);
        @(posedge clk);
        @(negedge clk);
        sample(0, rdy, ack, rd, er);
        n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack1 got %b want 1", ack); end
        n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1 got %b want 1", rdy); end
        drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h40, 32'd0);
        @(posedge clk);
        @(negedge clk);
        sample(0, rdy, ack, rd, er);
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack2 got %b want 1", ack); end
        n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready2 got %b want 1", rdy); end
        n_vec++; if (rd !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL b2b_rdata got %h want a5a50f0f", rd); end
        @(negedge clk);
        sample(0, rdy, ack, rd, er);
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", ack); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_merge();
        test_errors();
        test_wait();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
